// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer and its helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_DMEM_WAIT  = 2'b01,
    ST_HALT_DRAIN = 2'b10,
    ST_HALTED     = 2'b11
  } ctrl_state_e;

  localparam logic [4:0]  OPC_HALT  = 5'b00000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int          DRAIN_W   = 3;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: EX load whose destination is read by the ID instruction.
// r0 is an ordinary register here, so a match on r0 still counts.
module hazard_lu_detect #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_rs_used,
  input  logic             ID_rt_used,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  output logic             lu
);

  assign lu = EX_mem_read & EX_reg_write &
              ((ID_rs_used & (ID_rs == EX_rd)) | (ID_rt_used & (ID_rt == EX_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   state         | meaning
//   ST_RUN        | normal issue; branch > load-use > halt > fetch-wait priority
//   ST_DMEM_WAIT  | whole pipe frozen on a data access; resolves like RUN once ready
//   ST_HALT_DRAIN | HALT decoded, younger work flushed while older work drains
//   ST_HALTED     | program finished; PC held and fetch flushed until reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int REG_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_rs_used,
  input  logic             ID_rt_used,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  input  logic             br_taken_ex,
  input  logic             halt_id,
  input  logic             i_mem_busy,
  input  logic             d_mem_busy,
  output logic             stall_pc,
  output logic             stall_decode,
  output logic             flush_fetch,
  output logic             inst_stall,
  output logic             d_Stall,
  output logic             bubble_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  ctrl_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               lu;
  logic               pc_hold, dec_hold, ff, istall, dstall, bub, hlt;

  hazard_lu_detect #(.REG_W(REG_W)) u_lu (
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_rs_used   (ID_rs_used),
    .ID_rt_used   (ID_rt_used),
    .EX_rd        (EX_rd),
    .EX_mem_read  (EX_mem_read),
    .EX_reg_write (EX_reg_write),
    .lu           (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (pc_hold && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    pc_hold  = 1'b0;
    dec_hold = 1'b0;
    ff       = 1'b0;
    istall   = 1'b0;
    dstall   = 1'b0;
    bub      = 1'b0;
    hlt      = 1'b0;
    case (state_q)
      // DMEM_WAIT freezes exactly like RUN's top priority and falls through to
      // RUN resolution in the cycle the data access completes.
      ST_RUN, ST_DMEM_WAIT: begin
        if (d_mem_busy) begin
          dstall  = 1'b1;
          pc_hold = 1'b1;
          state_d = ST_DMEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if (br_taken_ex) begin
            ff  = 1'b1;
            bub = 1'b1;
          end else if (lu) begin
            pc_hold  = 1'b1;
            dec_hold = 1'b1;
            bub      = 1'b1;
          end else if (halt_id) begin
            pc_hold = 1'b1;
            ff      = 1'b1;
            drain_d = DRAIN_LOAD;
            state_d = ST_HALT_DRAIN;
          end else if (i_mem_busy) begin
            pc_hold = 1'b1;
            istall  = 1'b1;
          end
        end
      end
      ST_HALT_DRAIN: begin
        if (d_mem_busy) begin
          dstall  = 1'b1;
          pc_hold = 1'b1;
        end else if (br_taken_ex) begin
          ff      = 1'b1;
          bub     = 1'b1;
          drain_d = '0;
          state_d = ST_RUN;
        end else begin
          pc_hold = 1'b1;
          ff      = 1'b1;
          // Leave on the decrement that reaches zero so halted appears
          // DRAIN_CYCLES cycles after the HALT was decoded.
          if (drain_q <= DRAIN_W'(1)) begin
            drain_d = '0;
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end
      ST_HALTED: begin
        hlt     = 1'b1;
        pc_hold = 1'b1;
        ff      = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_pc     = pc_hold  & ~rst;
  assign stall_decode = dec_hold & ~rst;
  assign flush_fetch  = ff       & ~rst;
  assign inst_stall   = istall   & ~rst;
  assign d_Stall      = dstall   & ~rst;
  assign bubble_ex    = bub      & ~rst;
  assign halted       = hlt      & ~rst;
  assign stall_cycles = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected vectors.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ID_rs, ID_rt, EX_rd;
  logic       ID_rs_used, ID_rt_used, EX_mem_read, EX_reg_write;
  logic       br_taken_ex, halt_id, i_mem_busy, d_mem_busy;
  logic       stall_pc, stall_decode, flush_fetch, inst_stall, d_Stall, bubble_ex, halted;
  logic [3:0] stall_cycles;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // outs = {stall_pc, stall_decode, flush_fetch, inst_stall, d_Stall, bubble_ex, halted}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100010;
  localparam logic [6:0] O_BR    = 7'b0010010;
  localparam logic [6:0] O_IMEM  = 7'b1001000;
  localparam logic [6:0] O_DMEM  = 7'b1000100;
  localparam logic [6:0] O_DRAIN = 7'b1010000;
  localparam logic [6:0] O_HALT  = 7'b1010001;

  assign outs = {stall_pc, stall_decode, flush_fetch, inst_stall, d_Stall, bubble_ex, halted};

  pipe_hazard_ctrl #(.DRAIN_CYCLES(4), .REG_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .EX_reg_write(EX_reg_write),
    .br_taken_ex(br_taken_ex), .halt_id(halt_id),
    .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
    .stall_pc(stall_pc), .stall_decode(stall_decode), .flush_fetch(flush_fetch),
    .inst_stall(inst_stall), .d_Stall(d_Stall), .bubble_ex(bubble_ex),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 3'd1; ID_rt = 3'd2; ID_rs_used = 1'b0; ID_rt_used = 1'b0;
    EX_rd = 3'd7; EX_mem_read = 1'b0; EX_reg_write = 1'b0;
    br_taken_ex = 1'b0; halt_id = 1'b0; i_mem_busy = 1'b0; d_mem_busy = 1'b0;
  endtask

  task automatic lu_setup();
    EX_mem_read = 1'b1; EX_reg_write = 1'b1; EX_rd = 3'd3;
    ID_rs = 3'd3; ID_rs_used = 1'b1; ID_rt = 3'd5; ID_rt_used = 1'b1;
  endtask

  // advance one clock, then settle inputs away from the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    halt_id = 1'b1; i_mem_busy = 1'b1;
    #1;
    chk("rst_gates_outs", outs, O_IDLE);
    chk("rst_cnt", stall_cycles, 0);
    tick();
    rst = 1'b0; idle(); #1;
    chk("reset_state", outs, O_IDLE);
    chk("reset_cnt", stall_cycles, 0);

    // load-use on rs
    lu_setup(); #1;
    chk("lu_rs", outs, O_LU);
    tick();
    EX_mem_read = 1'b0; #1;
    chk("lu_cleared", outs, O_IDLE);
    chk("lu_cnt", stall_cycles, 1);

    // rt on r0; not read -> no hazard, non-writing EX -> no hazard, then hazard
    idle(); EX_mem_read = 1'b1; EX_reg_write = 1'b1; EX_rd = 3'd0;
    ID_rs = 3'd2; ID_rs_used = 1'b1; ID_rt = 3'd0; ID_rt_used = 1'b0; #1;
    chk("lu_rt_unused", outs, O_IDLE);
    ID_rt_used = 1'b1; EX_reg_write = 1'b0; #1;
    chk("lu_no_regwrite", outs, O_IDLE);
    EX_reg_write = 1'b1; #1;
    chk("lu_rt_r0", outs, O_LU);
    tick();
    idle(); #1;
    chk("lu_r0_cnt", stall_cycles, 2);

    // branch beats load-use, halt and fetch wait
    lu_setup(); br_taken_ex = 1'b1; halt_id = 1'b1; i_mem_busy = 1'b1; #1;
    chk("br_over_lu", outs, O_BR);
    tick();
    idle(); #1;
    chk("br_no_count", stall_cycles, 2);

    // halt loses to load-use
    lu_setup(); halt_id = 1'b1; #1;
    chk("lu_over_halt", outs, O_LU);
    tick();
    idle(); i_mem_busy = 1'b1; #1;
    chk("imem", outs, O_IMEM);
    tick();
    idle(); #1;
    chk("imem_cnt", stall_cycles, 4);

    // data-memory wait with branch and load-use ignored while frozen
    d_mem_busy = 1'b1; lu_setup(); #1;
    chk("dmem_c1", outs, O_DMEM);
    tick();
    br_taken_ex = 1'b1; #1;
    chk("dmem_c2_br", outs, O_DMEM);
    tick();
    br_taken_ex = 1'b0; halt_id = 1'b1; #1;
    chk("dmem_c3", outs, O_DMEM);
    tick();
    idle(); i_mem_busy = 1'b1; #1;
    chk("dmem_return_run", outs, O_IMEM);
    tick();
    idle(); #1;
    chk("dmem_cnt", stall_cycles, 8);

    // halt drain to halted
    do_reset();
    halt_id = 1'b1; #1;
    chk("halt_c0", outs, O_DRAIN);
    for (int k = 1; k <= 3; k++) begin
      tick(); idle(); #1;
      chk($sformatf("drain_c%0d", k), outs, O_DRAIN);
    end
    tick(); #1;
    chk("halted_c4", outs, O_HALT);
    chk("halted_cnt", stall_cycles, 4);
    for (int k = 5; k <= 14; k++) begin
      tick();
      idle(); br_taken_ex = (k == 7); d_mem_busy = (k == 9); #1;
      chk($sformatf("halted_c%0d", k), outs, O_HALT);
    end
    rst = 1'b1; #1;
    chk("rst_in_halted", outs, O_IDLE);
    tick();
    rst = 1'b0; idle(); #1;
    chk("after_halted_rst", outs, O_IDLE);

    // reset mid-drain aborts to RUN
    halt_id = 1'b1; #1;
    chk("halt2_c0", outs, O_DRAIN);
    tick();
    idle(); #1;
    chk("halt2_c1", outs, O_DRAIN);
    rst = 1'b1; #1;
    chk("rst_in_drain", outs, O_IDLE);
    chk("rst_in_drain_cnt", stall_cycles, 0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst_idle", outs, O_IDLE);
    chk("post_rst_cnt", stall_cycles, 0);
    i_mem_busy = 1'b1; #1;
    chk("post_rst_run", outs, O_IMEM);
    tick();

    // wrong-path halt
    idle(); halt_id = 1'b1; #1;
    chk("wp_c0", outs, O_DRAIN);
    tick();
    idle(); #1;
    chk("wp_c1", outs, O_DRAIN);
    tick();
    br_taken_ex = 1'b1; #1;
    chk("wp_br", outs, O_BR);
    tick();
    idle(); i_mem_busy = 1'b1; #1;
    chk("wp_run", outs, O_IMEM);
    for (int k = 0; k < 6; k++) begin
      tick(); idle(); #1;
      chk($sformatf("wp_idle%0d", k), outs, O_IDLE);
    end

    // data wait pauses the drain counter
    halt_id = 1'b1; #1;
    chk("pause_c0", outs, O_DRAIN);
    tick();
    idle(); d_mem_busy = 1'b1; #1;
    chk("pause_c1", outs, O_DMEM);
    tick();
    chk("pause_c2", outs, O_DMEM);
    tick();
    idle(); #1;
    for (int k = 3; k <= 5; k++) begin
      chk($sformatf("pause_drain%0d", k), outs, O_DRAIN);
      tick();
    end
    chk("pause_halted", outs, O_HALT);

    // saturation of the 4-bit stall counter
    do_reset();
    i_mem_busy = 1'b1; #1;
    for (int k = 0; k <= 20; k++) begin
      chk($sformatf("sat_cnt%0d", k), stall_cycles, (k < 15) ? k : 15);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
